// File: rtl/seg_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display: blank gap, then lit digit, per slot.
// All outputs registered (one clock after the deciding tick); no backpressure, en=0 parks the scan in BLANK.
module seg_scan_ctrl #(
    parameter int DIV             = 1000,
    parameter int BLANK_TICKS     = 1,
    parameter int ON_TICKS        = 4,
    parameter int FRAMES_PER_HALF = 250,
    parameter bit INVERT_SEG      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        auto,
    input  logic        man_sel,
    input  logic [31:0] seg_word,
    output logic        sel,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [1:0]  digit,
    output logic        frame_tick
);

    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TMAX = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int FW   = (FRAMES_PER_HALF > 1) ? $clog2(FRAMES_PER_HALF) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
    localparam logic [TW-1:0] B_LAST  = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0] O_LAST  = TW'(ON_TICKS - 1);
    localparam logic [FW-1:0] F_LAST  = FW'(FRAMES_PER_HALF - 1);
    localparam logic [7:0]    SEG_RST = INVERT_SEG ? 8'hFF : 8'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pcnt;
    logic            tick;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic [FW-1:0]   fcnt, fcnt_nxt;
    logic [1:0]      digit_nxt;
    logic [3:0]      an_nxt;
    logic [7:0]      seg_nxt;
    logic            sel_nxt;
    logic            frame_tick_nxt;
    logic [7:0]      cur_byte;

    // Prescaler: restarts from zero whenever the scan is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt <= '0;
        end else if (!en || pcnt == P_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign tick     = en && (pcnt == P_LAST);
    assign cur_byte = seg_word[{digit, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_BLANK;
            tcnt       <= '0;
            fcnt       <= '0;
            digit      <= 2'd0;
            an         <= 4'hF;
            seg        <= SEG_RST;
            sel        <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            tcnt       <= tcnt_nxt;
            fcnt       <= fcnt_nxt;
            digit      <= digit_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            sel        <= sel_nxt;
            frame_tick <= frame_tick_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tcnt_nxt       = tcnt;
        fcnt_nxt       = fcnt;
        digit_nxt      = digit;
        an_nxt         = an;
        seg_nxt        = seg;
        sel_nxt        = sel;
        frame_tick_nxt = 1'b0;

        if (!en) begin
            // Disable beats a coinciding frame end: sel, seg and frame count are left alone.
            state_nxt = ST_BLANK;
            tcnt_nxt  = '0;
            digit_nxt = 2'd0;
            an_nxt    = 4'hF;
        end else if (tick) begin
            case (state)
                ST_BLANK: begin
                    if (tcnt == B_LAST) begin
                        state_nxt = ST_ON;
                        tcnt_nxt  = '0;
                        an_nxt    = ~(4'b0001 << digit);
                        seg_nxt   = INVERT_SEG ? ~cur_byte : cur_byte;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
                ST_ON: begin
                    if (tcnt == O_LAST) begin
                        state_nxt = ST_BLANK;
                        tcnt_nxt  = '0;
                        an_nxt    = 4'hF;
                        if (digit == 2'd3) begin
                            // Frame boundary: the only place sel may move, always ahead of a BLANK.
                            digit_nxt      = 2'd0;
                            frame_tick_nxt = 1'b1;
                            if (auto) begin
                                if (fcnt == F_LAST) begin
                                    fcnt_nxt = '0;
                                    sel_nxt  = ~sel;
                                end else begin
                                    fcnt_nxt = fcnt + FW'(1);
                                end
                            end else begin
                                sel_nxt = man_sel;
                            end
                        end else begin
                            digit_nxt = digit + 2'd1;
                        end
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_BLANK;
                    tcnt_nxt  = '0;
                end
            endcase
        end

        // Manual mode pins the frame count so a later switch to auto starts counting from zero.
        if (!auto) begin
            fcnt_nxt = '0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random stimulus against a timeline-based model.
module tb_seg_scan_ctrl;

    localparam int DV  = 2;
    localparam int BT  = 1;
    localparam int OT  = 3;
    localparam int FPH = 2;
    localparam bit INV = 1'b1;

    localparam int SLOT  = (BT + OT) * DV;
    localparam int FRAME = 4 * SLOT;
    localparam int LIT   = BT * DV;

    localparam logic [31:0] W0 = 32'h3F06_5B4F;
    localparam logic [31:0] W1 = 32'h6D7D_077F;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        en = 1'b0;
    logic        auto = 1'b0;
    logic        man_sel = 1'b0;
    logic        conv = 1'b0;
    logic [31:0] raw_word = 32'h1234_5678;
    logic [31:0] seg_word;
    logic        sel;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  digit;
    logic        frame_tick;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Stand-in for the converter: the word follows sel when conv is set.
    assign seg_word = conv ? (sel ? W1 : W0) : raw_word;

    seg_scan_ctrl #(
        .DIV(DV), .BLANK_TICKS(BT), .ON_TICKS(OT),
        .FRAMES_PER_HALF(FPH), .INVERT_SEG(INV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .auto(auto), .man_sel(man_sel),
        .seg_word(seg_word), .sel(sel), .an(an), .seg(seg), .digit(digit),
        .frame_tick(frame_tick)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: position in the frame is the count of enabled clock edges since (re)start.
    int          k_m, fr_m, kn, dn, qn;
    logic        sel_m, ft_m;
    logic [3:0]  an_m;
    logic [7:0]  seg_m;
    logic [1:0]  dig_m;

    always_comb begin
        kn = (k_m + 1) % FRAME;
        dn = kn / SLOT;
        qn = kn % SLOT;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_m   <= 0;
            fr_m  <= 0;
            sel_m <= 1'b0;
            ft_m  <= 1'b0;
            an_m  <= 4'hF;
            seg_m <= INV ? 8'hFF : 8'h00;
            dig_m <= 2'd0;
        end else begin
            ft_m <= 1'b0;
            if (!en) begin
                k_m   <= 0;
                an_m  <= 4'hF;
                dig_m <= 2'd0;
            end else begin
                k_m   <= kn;
                an_m  <= (qn >= LIT) ? ~(4'b0001 << dn) : 4'hF;
                dig_m <= 2'(dn);
                if (qn == LIT)
                    seg_m <= INV ? ~seg_word[8*dn +: 8] : seg_word[8*dn +: 8];
                if (kn == 0) begin
                    ft_m <= 1'b1;
                    if (auto) begin
                        if (fr_m == FPH - 1) begin
                            fr_m  <= 0;
                            sel_m <= ~sel_m;
                        end else begin
                            fr_m <= fr_m + 1;
                        end
                    end else begin
                        sel_m <= man_sel;
                    end
                end
            end
            if (!auto) fr_m <= 0;
        end
    end

    always @(negedge clk) begin
        check_val("mdl_an", 32'(an), 32'(an_m));
        check_val("mdl_seg", 32'(seg), 32'(seg_m));
        check_val("mdl_sel", 32'(sel), 32'(sel_m));
        check_val("mdl_digit", 32'(digit), 32'(dig_m));
        check_val("mdl_frame_tick", 32'(frame_tick), 32'(ft_m));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_an"}, 32'(an), 32'h0000_000F);
        check_val({tag, "_seg"}, 32'(seg), 32'h0000_00FF);
        check_val({tag, "_sel"}, 32'(sel), 32'h0);
        check_val({tag, "_digit"}, 32'(digit), 32'h0);
        check_val({tag, "_ftick"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2 check_reset("rst_init");
        @(negedge clk);
        reset_n = 1'b1;
        en      = 1'b1;

        // Scan order and timing with a fixed word
        step(1);  check_val("t2_blank0_an", 32'(an), 32'hF);
        step(1);  check_val("t2_d0_an", 32'(an), 32'hE);  check_val("t2_d0_seg", 32'(seg), 32'h87);
        step(5);  check_val("t2_d0_end_an", 32'(an), 32'hE);
        step(1);  check_val("t2_blank1_an", 32'(an), 32'hF); check_val("t2_blank1_dig", 32'(digit), 32'h1);
        step(2);  check_val("t2_d1_an", 32'(an), 32'hD);  check_val("t2_d1_seg", 32'(seg), 32'hA9);
        step(8);  check_val("t2_d2_an", 32'(an), 32'hB);  check_val("t2_d2_seg", 32'(seg), 32'hCB);
        step(8);  check_val("t2_d3_an", 32'(an), 32'h7);  check_val("t2_d3_seg", 32'(seg), 32'hED);
        step(5);  check_val("t2_pre_ft", 32'(frame_tick), 32'h0);
        step(1);  check_val("t2_ft", 32'(frame_tick), 32'h1); check_val("t2_ft_an", 32'(an), 32'hF);
        step(1);  check_val("t2_ft_pulse", 32'(frame_tick), 32'h0);
        step(30); check_val("t2_pre_ft2", 32'(frame_tick), 32'h0);
        step(1);  check_val("t2_ft2", 32'(frame_tick), 32'h1);

        // Manual select raised during digit 1 lands at the frame end
        step(10); check_val("t4_d1_an", 32'(an), 32'hD);
        man_sel = 1'b1;
        step(21); check_val("t4_sel_hold", 32'(sel), 32'h0);
        step(1);  check_val("t4_sel_new", 32'(sel), 32'h1); check_val("t4_ft", 32'(frame_tick), 32'h1);
        step(1);  check_val("t4_gap_an", 32'(an), 32'hF);
        step(1);  check_val("t4_d0_an", 32'(an), 32'hE);

        // Enable drop during digit 2
        step(16); check_val("t5_d2_an", 32'(an), 32'hB);
        en = 1'b0;
        step(1);  check_val("t5_off_an", 32'(an), 32'hF); check_val("t5_off_dig", 32'(digit), 32'h0);
        check_val("t5_off_sel", 32'(sel), 32'h1); check_val("t5_off_seg", 32'(seg), 32'hCB);
        en = 1'b1;
        step(1);  check_val("t5_re_blank", 32'(an), 32'hF);
        step(1);  check_val("t5_re_d0", 32'(an), 32'hE); check_val("t5_re_seg", 32'(seg), 32'h87);

        // Asynchronous reset while a digit is lit and sel=1
        #2 reset_n = 1'b0;
        #1 check_reset("rst_lit");
        @(negedge clk);
        reset_n = 1'b1;
        auto    = 1'b1;
        conv    = 1'b1;

        // Auto alternation: sel 0,0,1,1,0 across frame ticks
        step(2);  check_val("t3_f0_seg", 32'(seg), 32'hB0);
        step(30); check_val("t3_ft1", 32'(frame_tick), 32'h1); check_val("t3_sel1", 32'(sel), 32'h0);
        step(32); check_val("t3_ft2", 32'(frame_tick), 32'h1); check_val("t3_sel2", 32'(sel), 32'h1);
        step(2);  check_val("t3_new_seg1", 32'(seg), 32'h80);
        step(30); check_val("t3_sel3", 32'(sel), 32'h1);
        step(32); check_val("t3_sel4", 32'(sel), 32'h0);
        step(2);  check_val("t3_new_seg0", 32'(seg), 32'hB0);
        step(30); check_val("t3_sel5", 32'(sel), 32'h0); check_val("t3_ft5", 32'(frame_tick), 32'h1);

        // en falls in the exact frame-end clock with frame count 1
        step(31);
        en = 1'b0;
        step(1);  check_val("t6_no_ft", 32'(frame_tick), 32'h0); check_val("t6_sel", 32'(sel), 32'h0);
        check_val("t6_an", 32'(an), 32'hF);
        en = 1'b1;
        step(32); check_val("t6_ft", 32'(frame_tick), 32'h1); check_val("t6_sel_tog", 32'(sel), 32'h1);

        // Random traffic, checked every cycle against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (en && $urandom_range(0, 199) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            if ($urandom_range(0, 299) == 0) auto = ~auto;
            if ($urandom_range(0, 39) == 0) man_sel = ~man_sel;
            if ($urandom_range(0, 49) == 0) raw_word = $urandom;
            if ($urandom_range(0, 399) == 0) conv = ~conv;
            if ($urandom_range(0, 999) == 0) begin
                #2 reset_n = 1'b0;
                #1 check_val("rnd_rst_an", 32'(an), 32'hF);
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
